// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: register enables, bubbles and flushes
// for load-use, mul/div occupancy, data-memory wait and taken-branch hazards.
//
// state   | meaning
// RUN     | mul/div unit idle
// MD_BUSY | mul/div unit occupied, md_cnt counts remaining busy cycles down to 0
module hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int STALL_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic                   id_muldiv_use,
    input  logic                   ex_memread,
    input  logic [4:0]             ex_rt,
    input  logic                   ex_muldiv_start,
    input  logic                   mem_branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   ifid_flush,
    output logic                   idex_en,
    output logic                   idex_bubble,
    output logic                   exmem_en,
    output logic                   exmem_flush,
    output logic                   memwb_bubble,
    output logic                   muldiv_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int MD_W = $clog2(MULDIV_CYCLES + 1);
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_CYCLES - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [MD_W-1:0] md_cnt, md_cnt_nxt;

    logic mem_wait;
    logic load_use;
    logic md_use;
    logic md_start;
    logic busy_int;

    always_comb begin
        busy_int = (state == MD_BUSY);
        mem_wait = mem_req & ~mem_ready;
        load_use = ex_memread & (ex_rt != 5'd0) &
                   ((id_use_rs & (id_rs == ex_rt)) | (id_use_rt & (id_rt == ex_rt)));
        md_use   = busy_int & id_muldiv_use;
        // a start held in a frozen EX stage must not restart the unit every cycle
        md_start = ex_muldiv_start & ~mem_wait;
    end

    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        case (state)
            RUN: begin
                if (md_start) begin
                    state_nxt  = MD_BUSY;
                    md_cnt_nxt = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_start) begin
                    md_cnt_nxt = MD_LOAD;
                end else if (md_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    md_cnt_nxt = md_cnt - MD_W'(1);
                end
            end
            default: begin
                state_nxt  = RUN;
                md_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        muldiv_busy  = busy_int;
        if (!rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_en      = 1'b0;
            idex_bubble  = 1'b1;
            exmem_en     = 1'b0;
            exmem_flush  = 1'b1;
            memwb_bubble = 1'b1;
            muldiv_busy  = 1'b0;
        end else if (mem_wait) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use || md_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            md_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios followed by random traffic, all checked
// against a remaining-busy-cycles / stall-count reference model.
module tb_hazard_ctrl;

    localparam int N = 4;
    localparam int W = 4;
    localparam int SAT = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   id_rs, id_rt, ex_rt;
    logic         id_use_rs, id_use_rt, id_muldiv_use;
    logic         ex_memread, ex_muldiv_start;
    logic         mem_branch_taken, mem_req, mem_ready;
    logic         pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
    logic         exmem_en, exmem_flush, memwb_bubble, muldiv_busy;
    logic [W-1:0] stall_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int busy_left = 0;
    int stalls    = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULDIV_CYCLES(N), .STALL_CNT_W(W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_muldiv_use(id_muldiv_use), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .ex_muldiv_start(ex_muldiv_start), .mem_branch_taken(mem_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_bubble(memwb_bubble), .muldiv_busy(muldiv_busy), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_muldiv_use = 1'b0;
        ex_memread = 1'b0; ex_muldiv_start = 1'b0;
        mem_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied; checks, then advances one cycle.
    task automatic step(input string tag);
        logic mw, lu, busy;
        logic e_pc, e_ifid, e_ifl, e_idex, e_idb, e_exm, e_exf, e_mwb, e_busy;
        #1;
        busy = (busy_left > 0);
        mw   = mem_req && !mem_ready;
        lu   = ex_memread && ex_rt != 0 &&
               ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
        {e_pc, e_ifid, e_ifl, e_idex, e_idb, e_exm, e_exf, e_mwb, e_busy} = 9'b110101000;
        e_busy = busy;
        if (!rst) begin
            {e_pc, e_ifid, e_ifl, e_idex, e_idb, e_exm, e_exf, e_mwb, e_busy} = 9'b001010110;
        end else if (mw) begin
            e_pc = 0; e_ifid = 0; e_idex = 0; e_exm = 0; e_mwb = 1;
        end else if (mem_branch_taken) begin
            e_ifl = 1; e_idb = 1; e_exf = 1;
        end else if (lu || (busy && id_muldiv_use)) begin
            e_pc = 0; e_ifid = 0; e_idb = 1;
        end
        check({tag, ".outs"},
              16'({pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
                   exmem_en, exmem_flush, memwb_bubble, muldiv_busy}),
              16'({e_pc, e_ifid, e_ifl, e_idex, e_idb, e_exm, e_exf, e_mwb, e_busy}));
        check({tag, ".stall_cnt"}, 16'(stall_cnt), 16'(stalls));
        @(posedge clk);
        if (!rst) begin
            busy_left = 0;
            stalls    = 0;
        end else begin
            if (!e_pc) stalls = (stalls < SAT) ? stalls + 1 : SAT;
            if (ex_muldiv_start && !mw) busy_left = N;
            else if (busy_left > 0)     busy_left--;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step("reset");
        rst = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        @(negedge clk);
        step("reset0");
        step("reset1");
        check("reset.stall_cnt", 16'(stall_cnt), 16'd0);
        rst = 1'b1;
        step("idle");

        // load-use for one cycle
        do_reset();
        ex_memread = 1; ex_rt = 5'd5; id_rs = 5'd5; id_use_rs = 1;
        step("lu");
        ex_memread = 0;
        step("lu_after");
        check("lu.stall_cnt", 16'(stall_cnt), 16'd1);

        // load to r0 never stalls
        do_reset();
        ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0; id_use_rs = 1;
        step("lu_r0");
        ex_memread = 0;
        step("lu_r0_after");
        check("lu_r0.stall_cnt", 16'(stall_cnt), 16'd0);

        // mul/div occupancy with dependent instruction waiting
        do_reset();
        ex_muldiv_start = 1;
        step("md_start");
        ex_muldiv_start = 0; id_muldiv_use = 1;
        for (int i = 0; i < N; i++) step("md_busy");
        check("md.stall_cnt", 16'(stall_cnt), 16'(N));
        step("md_done");
        check("md.busy_end", 16'(muldiv_busy), 16'd0);

        // restart at cycle 2 extends busy through cycle 6
        do_reset();
        ex_muldiv_start = 1;
        step("mdr_c0");
        ex_muldiv_start = 0;
        step("mdr_c1");
        ex_muldiv_start = 1;
        step("mdr_c2");
        ex_muldiv_start = 0;
        for (int i = 3; i <= 6; i++) step("mdr_busy");
        check("mdr.busy_c7", 16'(muldiv_busy), 16'd0);

        // branch beats load-use
        do_reset();
        ex_memread = 1; ex_rt = 5'd7; id_rt = 5'd7; id_use_rt = 1; mem_branch_taken = 1;
        step("br_lu");
        check("br.stall_cnt", 16'(stall_cnt), 16'd0);

        // memory wait freezes the pipe and holds the branch
        do_reset();
        mem_req = 1; mem_ready = 0; mem_branch_taken = 1;
        for (int i = 0; i < 3; i++) step("mw");
        mem_ready = 1;
        step("mw_ready");
        check("mw.stall_cnt", 16'(stall_cnt), 16'd3);

        // reset two cycles into mul/div
        do_reset();
        ex_muldiv_start = 1;
        step("rst_md0");
        ex_muldiv_start = 0;
        step("rst_md1");
        step("rst_md2");
        rst = 0;
        step("rst_mid");
        step("rst_hold");
        rst = 1;
        id_muldiv_use = 1;
        step("rst_release");
        check("rst.busy", 16'(muldiv_busy), 16'd0);

        // stall counter saturation
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 20; i++) step("sat");
        check("sat.stall_cnt", 16'(stall_cnt), 16'(SAT));

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 99) != 0);
            id_rs            = 5'($urandom_range(0, 3));
            id_rt            = 5'($urandom_range(0, 3));
            ex_rt            = 5'($urandom_range(0, 3));
            id_use_rs        = 1'($urandom);
            id_use_rt        = 1'($urandom);
            id_muldiv_use    = 1'($urandom);
            ex_memread       = 1'($urandom);
            ex_muldiv_start  = ($urandom_range(0, 7) == 0);
            mem_branch_taken = ($urandom_range(0, 5) == 0);
            mem_req          = 1'($urandom);
            mem_ready        = ($urandom_range(0, 2) != 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Generates load enables, bubble and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves load-use, multi-cycle mul/div, data-memory wait and taken-branch hazards.
- Tracks mul/div occupancy with an FSM/counter and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MULDIV_CYCLES, 32, cycles the mul/div unit stays busy after a start; legal range is 2 to 255.
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- id_rs  in  5  rs field of the ID-stage instruction.
- id_rt  in  5  rt field of the ID-stage instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_muldiv_use  in  1  ID instruction reads HI/LO or is a mul/div.
- ex_memread  in  1  MemRead of the EX-stage instruction (ID/EX output).
- ex_rt  in  5  Rt of the EX-stage instruction (load destination).
- ex_muldiv_start  in  1  EX-stage instruction is a mul/div; one-cycle pulse.
- mem_branch_taken  in  1  branch resolved taken in MEM.
- mem_req  in  1  MEM stage performs a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  clear IF/ID to NOP on next edge.
- idex_en  out  1  ID/EX load enable.
- idex_bubble  out  1  load zeros into all ID/EX control bits.
- exmem_en  out  1  EX/MEM load enable.
- exmem_flush  out  1  clear EX/MEM control bits.
- memwb_bubble  out  1  load zeros into MEM/WB control bits.
- muldiv_busy  out  1  mul/div unit occupied.
- stall_cnt  out  STALL_CNT_W  count of cycles with pc_en=0.

Behaviour:
- FSM states: RUN and MD_BUSY. Down-counter md_cnt is $clog2(MULDIV_CYCLES+1) bits.
- Reset (rst=0 at an edge): state=RUN, md_cnt=0, stall_cnt=0.
  - While rst=0, outputs are forced: all *_en=0, ifid_flush=1, idex_bubble=1, exmem_flush=1, memwb_bubble=1, muldiv_busy=0.
  - Reset mid-operation abandons any mul/div in progress.
- Default outputs when no hazard: all *_en=1; flush, bubble and busy=0.
- Hazard conditions are combinational from inputs and state, with zero-cycle latency.
- Priority, highest first:
  1. MEMWAIT: mem_req & ~mem_ready.
     - pc_en, ifid_en, idex_en, exmem_en = 0; memwb_bubble=1.
     - Branch, load-use and muldiv-use are suppressed this cycle and re-evaluated next cycle.
  2. BRANCH: mem_branch_taken.
     - ifid_flush=1, idex_bubble=1, exmem_flush=1; pc_en=1 (PC source selected elsewhere).
     - Load-use and muldiv-use are ignored because the wrong-path instructions are squashed.
  3. LOADUSE: ex_memread & ex_rt!=0 & ((id_use_rs & id_rs==ex_rt) | (id_use_rt & id_rt==ex_rt)).
     - pc_en=0, ifid_en=0, idex_bubble=1.
     - Lasts exactly one cycle, since the bubble removes the load match.
  4. MDUSE: muldiv_busy & id_muldiv_use.
     - pc_en=0, ifid_en=0, idex_bubble=1, held until muldiv_busy falls.
- FSM transitions:
  - RUN: on ex_muldiv_start, with idex_en=1 or ignoring idex_en, go to MD_BUSY with md_cnt=MULDIV_CYCLES-1.
  - MD_BUSY: muldiv_busy=1.
    - md_cnt decrements every cycle, including during MEMWAIT; the unit runs independently.
    - At md_cnt==0 with no start, return to RUN.
    - ex_muldiv_start in MD_BUSY reloads md_cnt=MULDIV_CYCLES-1 and stays (restart).
  - muldiv_busy is high for exactly MULDIV_CYCLES cycles, starting the cycle after the start pulse.
- ex_muldiv_start is qualified by ~MEMWAIT, so a frozen EX instruction is not re-issued.
- stall_cnt increments at each edge where rst=1 and pc_en=0, and saturates at all-ones.
- mem_ready without mem_req is ignored.

Test Plan:
- Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_use_rs=1 for one cycle, then ex_memread=0 -> pc_en=0, ifid_en=0, idex_bubble=1 for exactly 1 cycle; stall_cnt=1. Same stimulus with ex_rt=0 -> no stall.
- Mul/div: MULDIV_CYCLES=4; pulse ex_muldiv_start, then hold id_muldiv_use=1 -> muldiv_busy high for cycles 1-4 and pc_en=0 for those 4 cycles; a second start at cycle 2 extends busy to cycle 6.
- Branch: mem_branch_taken=1 together with a load-use match -> ifid_flush=idex_bubble=exmem_flush=1, pc_en=1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles with mem_branch_taken=1 -> all enables 0 and memwb_bubble=1 for 3 cycles; on the 4th cycle (ready) the branch flush fires; stall_cnt=3.
- Reset mid-operation: assert rst=0 two cycles into MD_BUSY -> next edge gives muldiv_busy=0 and stall_cnt=0, with forced outputs while rst=0; after release, state is RUN with defaults.
- Saturation: STALL_CNT_W=4; hold a MEMWAIT for 20 cycles -> stall_cnt stops at 15.
